clock_tap_monitor: RTL and testbench

CLOCK_TAP_MONITOR -- requirements
Module: clock_tap_monitor

---
 rtl/clock_tap_monitor.sv | 182 ++++++++++++++++++
 tb/tb_clock_tap_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_tap_monitor.sv
// clock_tap_monitor: watches the one-hot delay-tap enable of a clock
// controller, tracks the current/min/max tap, counts tap steps, keeps sticky
// health flags and queues tap-change / error events for a consumer.
module clock_tap_monitor #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [511:0] en,
   input  logic [2:0]   status,
   input  logic         clear,
   output logic [8:0]   tap_cur,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [8:0]   out_tap,
   output logic [1:0]   out_dir,
   output logic [8:0]   tap_min,
   output logic [8:0]   tap_max,
   output logic [15:0]  step_count,
   output logic [3:0]   flags
);

   localparam int AW = $clog2(FIFO_DEPTH);

   // Bit b of the encoded tap is set when the hot bit sits at an index whose bit b is 1.
   function automatic logic [511:0] idx_mask(input int b);
      logic [511:0] m;
      m = '0;
      for (int i = 0; i < 512; i++) begin
         m[i] = ((i >> b) & 1) == 1;
      end
      return m;
   endfunction

   // Stage 1 registers
   logic [511:0] en_q;
   logic [2:0]   status_q;
   logic [2:0]   status_prev_q;
   logic         s1_vld_q;

   // Statistics / tracking state
   logic [8:0]   tap_cur_q, tap_cur_d;
   logic [8:0]   tap_min_q, tap_min_d;
   logic [8:0]   tap_max_q, tap_max_d;
   logic [15:0]  step_q, step_d;
   logic [3:0]   flags_q, flags_d;
   logic         init_q, init_d;

   // Event FIFO
   logic [10:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;

   // Stage 2 decode
   logic         onehot;
   logic [8:0]   tap_enc;
   logic         push_req, push_ok, pop, full, err_set, overflow_set;
   logic [8:0]   push_tap;
   logic [1:0]   push_dir;
   logic [10:0]  head;
   logic         status_unused;

   assign status_unused = status_q[0];

   // Capture the raw controller inputs; the valid bit drops across reset and clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         en_q          <= '0;
         status_q      <= '0;
         status_prev_q <= '0;
         s1_vld_q      <= 1'b0;
      end else begin
         en_q          <= en;
         status_q      <= status;
         status_prev_q <= status_q;
         s1_vld_q      <= !clear;
      end
   end

   assign onehot = (en_q != '0) && ((en_q & (en_q - 512'd1)) == '0);

   genvar gi;
   generate
      for (gi = 0; gi < 9; gi++) begin : g_enc
         localparam logic [511:0] MASK = idx_mask(gi);
         assign tap_enc[gi] = |(en_q & MASK);
      end
   endgenerate

   // Classify the stage-1 sample into init / step event / error event
   always_comb begin
      push_req  = 1'b0;
      push_tap  = tap_cur_q;
      push_dir  = 2'b00;
      err_set   = 1'b0;
      init_d    = init_q;
      tap_cur_d = tap_cur_q;
      tap_min_d = tap_min_q;
      tap_max_d = tap_max_q;
      step_d    = step_q;
      if (s1_vld_q) begin
         if (!onehot) begin
            push_req = 1'b1;
            err_set  = 1'b1;
         end else begin
            tap_cur_d = tap_enc;
            if (tap_enc < tap_min_q) tap_min_d = tap_enc;
            if (tap_enc > tap_max_q) tap_max_d = tap_enc;
            if (!init_q) begin
               init_d = 1'b1;
            end else if (tap_enc != tap_cur_q) begin
               push_req = 1'b1;
               push_tap = tap_enc;
               // 10-bit compares so 511->0 is a jump, not a wrapped up-step
               if ({1'b0, tap_enc} == {1'b0, tap_cur_q} + 10'd1)
                  push_dir = 2'b01;
               else if ({1'b0, tap_enc} + 10'd1 == {1'b0, tap_cur_q})
                  push_dir = 2'b10;
               else
                  push_dir = 2'b11;
               if (step_q != 16'hFFFF) step_d = step_q + 16'd1;
            end
         end
      end
   end

   assign full         = count_q == (AW+1)'(FIFO_DEPTH);
   assign out_valid    = count_q != '0;
   assign pop          = out_valid && out_ready && !clear;
   assign push_ok      = push_req && !clear && (!full || pop);
   assign overflow_set = push_req && full && !pop;
   assign head         = mem_q[rd_ptr_q];
   assign out_tap      = out_valid ? head[10:2] : 9'd0;
   assign out_dir      = out_valid ? head[1:0]  : 2'b00;

   assign flags_d = flags_q | {overflow_set, err_set,
                               status_prev_q[2] & ~status_q[2], status_q[1]};

   // Statistics, sticky flags and init state; clear outranks every update
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         tap_cur_q <= '0;
         tap_min_q <= 9'd511;
         tap_max_q <= '0;
         step_q    <= '0;
         flags_q   <= '0;
         init_q    <= 1'b0;
      end else begin
         tap_cur_q <= tap_cur_d;
         tap_min_q <= tap_min_d;
         tap_max_q <= tap_max_d;
         step_q    <= step_d;
         flags_q   <= flags_d;
         init_q    <= init_d;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!resetn || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      end
   end

   // FIFO storage; contents are only observed through the gated head
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {push_tap, push_dir};
   end

   assign tap_cur    = tap_cur_q;
   assign tap_min    = tap_min_q;
   assign tap_max    = tap_max_q;
   assign step_count = step_q;
   assign flags      = flags_q;

endmodule

// File: tb/tb_clock_tap_monitor.sv
// Testbench for clock_tap_monitor: directed scenarios with literal checks plus
// a per-cycle comparison against a queue-based behavioural model.
module tb_clock_tap_monitor;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         resetn;
   logic [511:0] en;
   logic [2:0]   status;
   logic         clear;
   logic         out_ready;
   logic [8:0]   tap_cur, out_tap, tap_min, tap_max;
   logic         out_valid;
   logic [1:0]   out_dir;
   logic [15:0]  step_count;
   logic [3:0]   flags;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   clock_tap_monitor #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .en(en), .status(status), .clear(clear),
      .tap_cur(tap_cur), .out_valid(out_valid), .out_ready(out_ready),
      .out_tap(out_tap), .out_dir(out_dir), .tap_min(tap_min), .tap_max(tap_max),
      .step_count(step_count), .flags(flags)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int tap; int dir; } ev_t;
   ev_t q[$];
   logic [511:0] m_en = '0;
   logic [2:0]   m_st = '0, m_prev = '0;
   bit           m_vld = 0, m_init = 0;
   int           m_cur = 0, m_min = 511, m_max = 0, m_step = 0;
   bit [3:0]     m_flags = '0;

   always @(posedge clk) begin : model_p
      bit  push, pop;
      ev_t ev;
      int  idx;
      if (!resetn) begin
         q.delete();
         m_en = '0; m_st = '0; m_prev = '0; m_vld = 0; m_init = 0;
         m_cur = 0; m_min = 511; m_max = 0; m_step = 0; m_flags = '0;
      end else if (clear) begin
         q.delete();
         m_cur = 0; m_min = 511; m_max = 0; m_step = 0; m_flags = '0; m_init = 0;
         m_prev = m_st; m_st = status; m_en = en; m_vld = 0;
      end else begin
         pop  = (q.size() > 0) && out_ready;
         push = 0;
         ev   = '{0, 0};
         if (m_vld) begin
            if ($countones(m_en) != 1) begin
               push = 1;
               ev = '{m_cur, 0};
               m_flags[2] = 1;
            end else begin
               idx = 0;
               for (int i = 0; i < 512; i++) if (m_en[i]) idx = i;
               if (!m_init) begin
                  m_init = 1;
               end else if (idx != m_cur) begin
                  push = 1;
                  ev.tap = idx;
                  ev.dir = (idx == m_cur + 1) ? 1 : (idx == m_cur - 1) ? 2 : 3;
                  if (m_step < 65535) m_step++;
               end
               m_cur = idx;
               if (idx < m_min) m_min = idx;
               if (idx > m_max) m_max = idx;
            end
         end
         if (m_prev[2] && !m_st[2]) m_flags[1] = 1;
         if (m_st[1]) m_flags[0] = 1;
         if (pop) void'(q.pop_front());
         if (push) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else m_flags[3] = 1;
         end
         m_prev = m_st; m_st = status; m_en = en; m_vld = 1;
      end
   end

   // Compare every DUT output against the model on the falling edge
   always @(negedge clk) begin
      chk("cyc_tap_cur", tap_cur, m_cur);
      chk("cyc_tap_min", tap_min, m_min);
      chk("cyc_tap_max", tap_max, m_max);
      chk("cyc_step", step_count, m_step);
      chk("cyc_flags", flags, m_flags);
      chk("cyc_out_valid", out_valid, q.size() > 0);
      chk("cyc_out_tap", out_tap, (q.size() > 0) ? q[0].tap : 0);
      chk("cyc_out_dir", out_dir, (q.size() > 0) ? q[0].dir : 0);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] oh(input int k);
      logic [511:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // ---------------- directed stimulus ----------------
   initial begin
      resetn = 0; en = '0; status = '0; clear = 0; out_ready = 1;
      tick(3);
      chk("rst_tap_cur", tap_cur, 0);
      chk("rst_tap_min", tap_min, 511);
      chk("rst_tap_max", tap_max, 0);
      chk("rst_flags", flags, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_tap", out_tap, 0);

      // first valid sample initializes after two cycles
      en = oh(510); resetn = 1;
      tick(1);
      chk("lat_tap_cur", tap_cur, 0);
      tick(1);
      chk("init_tap_cur", tap_cur, 510);
      chk("init_min", tap_min, 510);
      chk("init_max", tap_max, 510);
      chk("init_valid", out_valid, 0);
      chk("init_step", step_count, 0);

      // down step
      en = oh(509);
      tick(2);
      chk("down_valid", out_valid, 1);
      chk("down_tap", out_tap, 509);
      chk("down_dir", out_dir, 2);
      chk("down_step", step_count, 1);
      chk("down_min", tap_min, 509);

      // clear, re-init at 100, then jump to 300
      clear = 1; en = oh(100);
      tick(1);
      clear = 0;
      tick(2);
      chk("reinit_tap", tap_cur, 100);
      chk("reinit_max", tap_max, 100);
      chk("reinit_valid", out_valid, 0);
      chk("reinit_step", step_count, 0);
      en = oh(300);
      tick(2);
      chk("jump_tap", out_tap, 300);
      chk("jump_dir", out_dir, 3);
      chk("jump_max", tap_max, 300);
      chk("jump_step", step_count, 1);
      tick(1);
      chk("jump_popped", out_valid, 0);

      // one invalid (all-zero) sample
      en = '0;
      tick(1);
      en = oh(300);
      tick(1);
      chk("err_valid", out_valid, 1);
      chk("err_dir", out_dir, 0);
      chk("err_tap", out_tap, 300);
      chk("err_flags", flags, 4'b0100);
      chk("err_tap_cur", tap_cur, 300);
      tick(1);
      chk("err_popped", out_valid, 0);

      // six up-steps with consumer stalled: four kept, overflow flagged
      out_ready = 0;
      for (int k = 1; k <= 6; k++) begin
         en = oh(300 + k);
         tick(1);
      end
      tick(2);
      chk("ovf_flags", flags, 4'b1100);
      chk("ovf_head_tap", out_tap, 301);
      chk("ovf_head_dir", out_dir, 1);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_tap", out_tap, 301 + i);
         tick(1);
      end
      chk("drain_empty", out_valid, 0);

      // lock loss and rail flags, then clear
      status = 3'b100; tick(3);
      status = 3'b000; tick(3);
      chk("lock_lost", flags, 4'b1110);
      status = 3'b010; tick(2);
      chk("rail_hit", flags, 4'b1111);
      status = 3'b000; tick(2);
      clear = 1; tick(1); clear = 0;
      chk("clr_flags", flags, 0);
      chk("clr_step", step_count, 0);
      chk("clr_valid", out_valid, 0);
      chk("clr_min", tap_min, 511);
      chk("clr_tap_cur", tap_cur, 0);
      tick(2);
      chk("clr_reinit", tap_cur, 306);
      chk("clr_noevent", out_valid, 0);

      // reset mid-operation with events queued
      out_ready = 0;
      en = oh(307); tick(1);
      en = oh(309); tick(2);
      resetn = 0; tick(1);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_tap", tap_cur, 0);
      en = oh(5); resetn = 1;
      tick(2);
      chk("mid_reinit", tap_cur, 5);
      chk("mid_reinit_valid", out_valid, 0);

      // push and pop in the same cycle while full
      for (int k = 6; k <= 9; k++) begin
         en = oh(k);
         tick(1);
      end
      en = oh(10); tick(1);
      out_ready = 1; tick(1);
      chk("full_pp_flags", flags, 0);
      chk("full_pp_head", out_tap, 7);
      tick(6);
      chk("full_pp_empty", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
